// File: rtl/pipes.sv
// Shared execute-stage types: the M-extension operation select and its decode helpers.
package pipes;

    typedef enum logic [3:0] {
        MDU_MUL,
        MDU_MULW,
        MDU_DIV,
        MDU_DIVU,
        MDU_REM,
        MDU_REMU,
        MDU_DIVW,
        MDU_DIVUW,
        MDU_REMW,
        MDU_REMUW
    } mdufunc_t;

    function automatic logic is_word(mdufunc_t f);
        case (f)
            MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed(mdufunc_t f);
        case (f)
            MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(mdufunc_t f);
        case (f)
            MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Any encoding that is not a divide/remainder, including illegal ones, runs as a multiply.
    function automatic logic is_div(mdufunc_t f);
        case (f)
            MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
            MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring radix-2 divider datapath: one quotient bit per step on unsigned 64-bit operands.
module mdu_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dsr_q;
    logic [64:0] diff;
    logic [63:0] rem_next;

    // The dividend shifts out of quo_q's top as quotient bits shift into its bottom.
    always_comb begin
        diff     = {rem_q, quo_q[63]} - {1'b0, dsr_q};
        rem_next = diff[64] ? {rem_q[62:0], quo_q[63]} : diff[63:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= 64'd0;
            quo_q <= 64'd0;
            dsr_q <= 64'd0;
        end else if (load) begin
            rem_q <= 64'd0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= {quo_q[62:0], ~diff[64]};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative RV64 multiply/divide unit with valid/ready request and response handshakes.
module mdu
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  mdufunc_t    mdufunc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] c
);

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic        word_q, div_q, rem_op_q, negq_q, negr_q, dz_q, ovf_q;
    logic [63:0] ea_q, acc_q, mcand_q, mplier_q, c_q;

    logic        word, sgn, accept;
    logic [63:0] ea, eb, abs_a, abs_b, dividend;
    logic [63:0] quotient, remainder, q_fix, r_fix, res_raw, result;
    logic [5:0]  last;

    always_comb begin
        word  = is_word(mdufunc);
        sgn   = is_signed(mdufunc);
        ea    = word ? {{32{sgn & a[31]}}, a[31:0]} : a;
        eb    = word ? {{32{sgn & b[31]}}, b[31:0]} : b;
        abs_a = (sgn && ea[63]) ? -ea : ea;
        abs_b = (sgn && eb[63]) ? -eb : eb;
        // Word divides pre-shift the dividend so 32 steps consume exactly its low 32 bits.
        dividend = word ? {abs_a[31:0], 32'd0} : abs_a;
        accept   = (state_q == StIdle) && req_valid && !flush;
        last     = word_q ? 6'd31 : 6'd63;
    end

    mdu_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      ((state_q == StBusy) && div_q),
        .dividend  (dividend),
        .divisor   (abs_b),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = StBusy;
            StBusy: if (cnt_q == last) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StDone);
        c          = c_q;
    end

    always_comb begin
        q_fix = negq_q ? -quotient : quotient;
        r_fix = negr_q ? -remainder : remainder;
        if (!div_q) begin
            res_raw = acc_q;
        end else if (dz_q) begin
            res_raw = rem_op_q ? ea_q : {64{1'b1}};
        end else if (ovf_q) begin
            res_raw = rem_op_q ? 64'd0 : ea_q;
        end else begin
            res_raw = rem_op_q ? r_fix : q_fix;
        end
        result = word_q ? {{32{res_raw[31]}}, res_raw[31:0]} : res_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 6'd0;
            word_q   <= 1'b0;
            div_q    <= 1'b0;
            rem_op_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            ea_q     <= 64'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 64'd0;
            c_q      <= 64'd0;
        end else begin
            if (accept) begin
                cnt_q    <= 6'd0;
                word_q   <= word;
                div_q    <= is_div(mdufunc);
                rem_op_q <= is_rem(mdufunc);
                negq_q   <= sgn & (ea[63] ^ eb[63]);
                negr_q   <= sgn & ea[63];
                dz_q     <= (eb == 64'd0);
                ovf_q    <= sgn && (eb == {64{1'b1}}) &&
                            (ea == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
                ea_q     <= ea;
                acc_q    <= 64'd0;
                mcand_q  <= ea;
                mplier_q <= eb;
            end else if (state_q == StBusy) begin
                cnt_q    <= cnt_q + 6'd1;
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= {mcand_q[62:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[63:1]};
            end
            if (state_q == StFix) c_q <= result;
        end
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the RV64 execute stage. It is the iterative counterpart of the single-cycle ALU and takes the same forwarded 64-bit operands. It returns `c` through a valid/ready handshake, so the pipeline can stall on long-latency M-extension operations. It covers MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW, with exact RISC-V corner-case semantics.

## Interface
Parameters:
- none; the data width is fixed at 64 (`u64`).

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: squash the in-flight operation (pipeline redirect).
- `req_valid` in 1: the request below is valid.
- `req_ready` out 1: the unit can accept a request.
- `a` in 64: operand rs1.
- `b` in 64: operand rs2.
- `mdufunc` in `mdufunc_t`: operation select.
- `resp_valid` out 1: `c` is valid.
- `resp_ready` in 1: the consumer takes `c`.
- `c` out 64: result.

## Operation
- State machine: IDLE, BUSY, FIX, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch the operands and function, preprocess them, clear the counter, and go to BUSY.
- Preprocessing:
  - W ops use `a[31:0]`/`b[31:0]`. Signed W ops sign-extend these to 64 bits first; unsigned W ops zero-extend them.
  - Signed div/rem takes absolute values and records `neg_q` = sign(a)^sign(b) and `neg_r` = sign(a).
- BUSY, multiply:
  - Shift-add, one bit of `b` per cycle, product kept modulo 2^64.
  - Signed and unsigned give identical low bits, so no sign fix-up is needed.
- BUSY, divide:
  - Restoring radix-2, one quotient bit per cycle, using a 64-bit remainder register with a 65-bit trial subtract.
- Iteration count: 64 for 64-bit ops, 32 for W ops. The counter runs 0..N-1; at N-1 the state goes to FIX.
- FIX: result selection and sign correction.
  - Divide by zero (b==0 after W truncation): quotient = all ones, remainder = a (the truncated, extended value).
  - Signed overflow (a = most-negative, b = −1): quotient = a, remainder = 0.
  - Otherwise negate the quotient and/or remainder per `neg_q`/`neg_r`.
  - W results are sign-extended from bit 31. This applies to DIVUW/REMUW as well.
  - Special cases still take the full iteration latency.
- DONE:
  - `resp_valid`=1 and `c` is stable.
  - On `resp_ready`: go to IDLE.
  - `req_ready`=0; a new request is accepted only from IDLE, one cycle after the response handshake.
- `flush`: from any state, the next state is IDLE, no response is produced, and `c` is don't-care. Flush outranks `resp_ready` and `req_valid` in the same cycle.
- Illegal `mdufunc`: treated as MUL.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `c`=0, counter=0.
- Accept at edge E: `resp_valid` rises after edge E+N+1, where N=64 (or 32 for W ops). This is N BUSY cycles plus 1 FIX cycle. Total is 66 cycles to handshake for 64-bit ops and 34 for W ops, including the DONE cycle.
- `resp_valid` holds, with `c` unchanged, for as long as `resp_ready`=0.
- `req_ready` is combinational from the state only, with no input dependence.
- Reset mid-operation behaves exactly like flush, and all registers return to their reset values.
- `req_valid` together with `flush` in IDLE: the request is not accepted.

## Structure
- `mdufunc_t` lives in package `pipes`:
  - enum values: MDU_MUL, MDU_MULW, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW.
  - helpers to place alongside it: `is_word`, `is_signed`, `is_rem`.
- The state enum is local to the module.
- One sub-module: `mdu_divider`, which holds the restoring-division datapath (remainder/quotient registers and the per-cycle step). Multiply and control stay in `mdu`.

## Test plan
- MUL a=3, b=0xFFFF_FFFF_FFFF_FFFB (−5) → c=0xFFFF_FFFF_FFFF_FFF1; `resp_valid` asserts exactly 65 cycles after the accept edge.
- DIV a=7, b=0 → c=0xFFFF_FFFF_FFFF_FFFF; REM a=7, b=0 → c=7; DIVU a=0, b=0 → all ones.
- DIV a=0x8000_0000_0000_0000, b=−1 → c=0x8000_0000_0000_0000; REM with the same operands → 0. DIV a=−7, b=2 → −3; REM → −1.
- DIVW a=0x1_8000_0000, b=0xFFFF_FFFF → c=0xFFFF_FFFF_8000_0000. DIVUW a=0xFFFF_FFFF, b=1 → c=0xFFFF_FFFF_FFFF_FFFF, latency 33. MULW a=0x7FFF_FFFF, b=2 → c=0xFFFF_FFFF_FFFF_FFFE.
- Back-pressure: hold `resp_ready`=0 for 10 cycles after `resp_valid` → `c` stable and `req_ready`=0 throughout. A request offered at handshake+1 is accepted.
- Flush at BUSY cycle 20 (and, separately, `reset` at cycle 20) → IDLE next cycle, no `resp_valid` ever. The following MUL 6×7 returns 42 with nominal latency.
